// File: rtl/frame_cfg_pkg.sv
// Shared constants and types for the configuration frame writer:
// header field layout and the loader state encoding.
package frame_cfg_pkg;

  localparam logic [3:0] SYNC_NIBBLE = 4'hA;

  localparam int SYNC_HI = 31;
  localparam int SYNC_LO = 28;
  localparam int COL_HI  = 27;
  localparam int COL_LO  = 20;
  localparam int FRM_HI  = 19;
  localparam int FRM_LO  = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STROBE = 2'd2
  } frame_state_t;

endpackage

// File: rtl/frame_strobe_writer_if.sv
// Word-stream handshake from the bitstream loader into the frame writer.
interface frame_strobe_writer_if #(
  parameter int FrameBitsPerRow = 32
) ();

  logic [FrameBitsPerRow-1:0] WordIn;
  logic                       WordValid;
  logic                       WordReady;

  modport master (output WordIn, output WordValid, input WordReady);
  modport slave  (input WordIn, input WordValid, output WordReady);

endinterface

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decode of (column, frame) onto the fabric strobe lines;
// all lines are low in every cycle where en was low on the preceding edge.
module frame_strobe_decoder #(
  parameter int NumColumns      = 10,
  parameter int MaxFramesPerCol = 20
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [$clog2(NumColumns)-1:0]         col,
  input  logic [$clog2(MaxFramesPerCol)-1:0]    frame,
  input  logic                                  en,
  output logic [NumColumns*MaxFramesPerCol-1:0] strobe
);

  localparam int IW = $clog2(NumColumns*MaxFramesPerCol);

  logic [IW-1:0] idx;

  assign idx = IW'(col) * IW'(MaxFramesPerCol) + IW'(frame);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe <= '0;
    end else begin
      strobe <= '0;
      if (en) strobe[idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/frame_strobe_writer.sv
// Assembles one frame column slice (one word per tile row) from a header +
// data word stream, then pulses the addressed frame strobe for one cycle.
module frame_strobe_writer
  import frame_cfg_pkg::*;
#(
  parameter int NumColumns      = 10,
  parameter int NumRows         = 16,
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20
) (
  input  logic                                  UserCLK,
  input  logic                                  RST,
  frame_strobe_writer_if.slave                  word_bus,
  output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  Busy,
  output logic                                  Error,
  input  logic                                  ErrClear
);

  localparam int RW = $clog2(NumRows);
  localparam int CW = $clog2(NumColumns);
  localparam int FW = $clog2(MaxFramesPerCol);
  localparam logic [7:0] COL_LIM = 8'(NumColumns);
  localparam logic [7:0] FRM_LIM = 8'(MaxFramesPerCol);

  frame_state_t               state;
  logic [RW-1:0]              row_cnt;
  logic [CW-1:0]              col_q;
  logic [FW-1:0]              frm_q;
  logic [FrameBitsPerRow-1:0] rows [NumRows];

  logic       xfer;
  logic       hdr_ok;
  logic       last_row;
  logic       strobe_en;
  logic [7:0] hdr_col;
  logic [7:0] hdr_frm;

  assign xfer      = word_bus.WordValid && word_bus.WordReady;
  assign hdr_col   = word_bus.WordIn[COL_HI:COL_LO];
  assign hdr_frm   = word_bus.WordIn[FRM_HI:FRM_LO];
  assign hdr_ok    = (word_bus.WordIn[SYNC_HI:SYNC_LO] == SYNC_NIBBLE) &&
                     (hdr_col < COL_LIM) && (hdr_frm < FRM_LIM);
  assign last_row  = (row_cnt == RW'(NumRows - 1));
  assign strobe_en = xfer && (state == LOAD) && last_row;

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      state              <= IDLE;
      row_cnt            <= '0;
      col_q              <= '0;
      frm_q              <= '0;
      word_bus.WordReady <= 1'b0;
      Busy               <= 1'b0;
      Error              <= 1'b0;
    end else begin
      // Clear first so that a coinciding bad header below wins.
      if (ErrClear) Error <= 1'b0;
      case (state)
        IDLE: begin
          word_bus.WordReady <= 1'b1;
          Busy               <= 1'b0;
          if (xfer) begin
            if (hdr_ok) begin
              col_q   <= CW'(hdr_col);
              frm_q   <= FW'(hdr_frm);
              row_cnt <= '0;
              Busy    <= 1'b1;
              state   <= LOAD;
            end else begin
              Error <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            if (last_row) begin
              row_cnt            <= '0;
              word_bus.WordReady <= 1'b0;
              state              <= STROBE;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        STROBE: begin
          word_bus.WordReady <= 1'b1;
          Busy               <= 1'b0;
          state              <= IDLE;
        end
        default: begin
          word_bus.WordReady <= 1'b0;
          Busy               <= 1'b0;
          state              <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NumRows; r++) rows[r] <= '0;
    end else if (xfer && (state == LOAD)) begin
      rows[row_cnt] <= word_bus.WordIn;
    end
  end

  for (genvar r = 0; r < NumRows; r++) begin : g_row
    assign FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] = rows[r];
  end

  frame_strobe_decoder #(
    .NumColumns      (NumColumns),
    .MaxFramesPerCol (MaxFramesPerCol)
  ) u_decoder (
    .clk    (UserCLK),
    .rst    (RST),
    .col    (col_q),
    .frame  (frm_q),
    .en     (strobe_en),
    .strobe (FrameStrobe)
  );

endmodule

// File: tb/tb_frame_strobe_writer.sv
// Directed bench for frame_strobe_writer: frame loads, header errors, stalls,
// back-to-back frames and mid-frame reset.
module tb_frame_strobe_writer;

  localparam int NC = 10;
  localparam int NR = 16;
  localparam int FB = 32;
  localparam int MF = 20;

  logic              clk;
  logic              rst;
  logic              err_clear;
  logic [NR*FB-1:0]  frame_data;
  logic [NC*MF-1:0]  frame_strobe;
  logic              busy;
  logic              error;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int last_strobe_cyc = 0;
  int prev_strobe_cyc = 0;
  int ready_glitch = 0;
  bit b2b_on = 0;

  frame_strobe_writer_if #(.FrameBitsPerRow(FB)) bus ();

  frame_strobe_writer #(
    .NumColumns(NC), .NumRows(NR), .FrameBitsPerRow(FB), .MaxFramesPerCol(MF)
  ) dut (
    .UserCLK     (clk),
    .RST         (rst),
    .word_bus    (bus.slave),
    .FrameData   (frame_data),
    .FrameStrobe (frame_strobe),
    .Busy        (busy),
    .Error       (error),
    .ErrClear    (err_clear)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_strobe != '0) begin
      strobe_cnt++;
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
    end
    if (b2b_on && !bus.WordReady && frame_strobe == '0) ready_glitch++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    bus.WordIn    = w;
    bus.WordValid = 1'b1;
    while (!bus.WordReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic load_frame(input logic [31:0] hdr, input logic [31:0] base, input int stall_after);
    int s0;
    send(hdr);
    for (int r = 0; r < NR; r++) begin
      send(base + 32'(r));
      if (r == stall_after) begin
        @(negedge clk);
        bus.WordValid = 1'b0;
        s0 = strobe_cnt;
        repeat (5) @(negedge clk);
        chk("stall_no_strobe", 512'(strobe_cnt), 512'(s0));
        chk("stall_busy", 512'(busy), 1);
      end
    end
  endtask

  task automatic expect_strobe(input int idx, input logic [31:0] base);
    logic [NC*MF-1:0] e;
    e = '0;
    e[idx] = 1'b1;
    @(negedge clk);
    bus.WordValid = 1'b0;
    chk($sformatf("strobe_bit%0d", idx), 512'(frame_strobe), 512'(e));
    chk("busy_in_strobe", 512'(busy), 1);
    chk("ready_in_strobe", 512'(bus.WordReady), 0);
    @(negedge clk);
    chk("strobe_off", 512'(frame_strobe), 0);
    chk("ready_after_strobe", 512'(bus.WordReady), 1);
    chk("busy_after_strobe", 512'(busy), 0);
    for (int r = 0; r < NR; r++)
      chk($sformatf("row%0d", r), 512'(frame_data[r*FB +: FB]), 512'(base + 32'(r)));
  endtask

  task automatic bad_header(input logic [31:0] hdr, input string tag);
    int s0;
    s0 = strobe_cnt;
    send(hdr);
    @(negedge clk);
    bus.WordValid = 1'b0;
    chk({tag, "_error"}, 512'(error), 1);
    chk({tag, "_busy"}, 512'(busy), 0);
    repeat (2) @(negedge clk);
    chk({tag, "_no_strobe"}, 512'(strobe_cnt), 512'(s0));
    chk({tag, "_ready"}, 512'(bus.WordReady), 1);
  endtask

  task automatic clear_error();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("err_clear", 512'(error), 0);
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    err_clear = 1'b0;
    bus.WordValid = 1'b0;
    bus.WordIn = '0;
    repeat (2) @(negedge clk);
    chk("rst_data", 512'(frame_data), 0);
    chk("rst_strobe", 512'(frame_strobe), 0);
    chk("rst_ready", 512'(bus.WordReady), 0);
    chk("rst_busy", 512'(busy), 0);
    chk("rst_error", 512'(error), 0);
    rst = 1'b0;
    #1 chk("ready_at_release", 512'(bus.WordReady), 0);
    @(negedge clk);
    chk("ready_after_release", 512'(bus.WordReady), 1);

    // Basic frame c=2 f=3 -> bit 43.
    s0 = strobe_cnt;
    load_frame(32'hA020_3000, 32'h100, -1);
    expect_strobe(43, 32'h100);
    chk("frame1_one_strobe", 512'(strobe_cnt), 512'(s0 + 1));

    // Header errors and clearing.
    bad_header(32'hB000_0000, "bad_sync");
    clear_error();
    err_clear = 1'b1;
    bad_header(32'hB000_0000, "set_wins");
    err_clear = 1'b0;
    clear_error();
    bad_header(32'hA0A0_0000, "col10");
    clear_error();
    bad_header(32'hA001_4000, "frm20");
    clear_error();

    // Highest legal address c=9 f=19 -> bit 199.
    s0 = strobe_cnt;
    load_frame(32'hA091_3000, 32'h180, -1);
    expect_strobe(199, 32'h180);
    chk("frame199_one_strobe", 512'(strobe_cnt), 512'(s0 + 1));

    // Stall after row 7, c=1 f=5 -> bit 25.
    s0 = strobe_cnt;
    load_frame(32'hA010_5000, 32'h200, 7);
    expect_strobe(25, 32'h200);
    chk("stall_one_strobe", 512'(strobe_cnt), 512'(s0 + 1));

    // Back-to-back: c=3 f=0 (bit 60) then c=4 f=7 (bit 87).
    s0 = strobe_cnt;
    ready_glitch = 0;
    b2b_on = 1;
    load_frame(32'hA030_0000, 32'h300, -1);
    load_frame(32'hA040_7000, 32'h400, -1);
    expect_strobe(87, 32'h400);
    b2b_on = 0;
    chk("b2b_strobes", 512'(strobe_cnt), 512'(s0 + 2));
    chk("b2b_spacing", 512'(last_strobe_cyc - prev_strobe_cyc), 18);
    chk("b2b_ready_only_strobe", 512'(ready_glitch), 0);

    // Leave Error set, then reset in the middle of a frame after row 10.
    bad_header(32'h1234_5678, "pre_rst");
    s0 = strobe_cnt;
    send(32'hA000_0000);
    for (int r = 0; r <= 10; r++) send(32'h600 + 32'(r));
    @(negedge clk);
    bus.WordValid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_data", 512'(frame_data), 0);
    chk("mid_rst_strobe", 512'(frame_strobe), 0);
    chk("mid_rst_ready", 512'(bus.WordReady), 0);
    chk("mid_rst_busy", 512'(busy), 0);
    chk("mid_rst_error", 512'(error), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_strobe", 512'(strobe_cnt), 512'(s0));

    s0 = strobe_cnt;
    load_frame(32'hA000_0000, 32'h500, -1);
    expect_strobe(0, 32'h500);
    chk("post_rst_one_strobe", 512'(strobe_cnt), 512'(s0 + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
